// File: rtl/uart_rx_framer.sv
// UART receive frame controller: qualifies the start bit on a synchronized
// RX line, gates the external bit sampler via sampler_rst, assembles the
// data bits LSB first from the sampler's decisions and checks the stop bit.
module uart_rx_framer #(
  parameter int DATA_BITS     = 8,
  parameter int START_SAMPLES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 raw_data,
  input  logic                 estimated_data,
  input  logic                 sample_clk,
  output logic                 sampler_rst,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam int SCW = 4;
  localparam logic [BCW-1:0] BIT_LAST   = BCW'(DATA_BITS - 1);
  localparam logic [SCW-1:0] START_LAST = SCW'(START_SAMPLES - 1);
  localparam logic [SCW-1:0] START_MAX  = SCW'(START_SAMPLES);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [SCW-1:0]       start_cnt_q, start_cnt_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 dv_d, fe_d, srst_d, busy_d;

  assign rx_s = sync_q[1];

  // Next-state, counter, datapath and registered-output decode.
  always_comb begin
    state_d     = state_q;
    start_cnt_d = start_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data;
    dv_d        = 1'b0;
    fe_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d     = START;
          start_cnt_d = SCW'(1);
        end
      end
      START: begin
        if (rx_s) begin
          // Line went high before qualification: treat as a glitch.
          state_d     = IDLE;
          start_cnt_d = '0;
        end else if (start_cnt_q >= START_LAST) begin
          state_d     = DATA;
          start_cnt_d = START_MAX;
          bit_cnt_d   = '0;
        end else begin
          start_cnt_d = start_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (sample_clk) begin
          shift_d   = {estimated_data, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) state_d = STOP;
        end
      end
      STOP: begin
        if (sample_clk) begin
          start_cnt_d = '0;
          if (estimated_data) begin
            data_d  = shift_q;
            dv_d    = 1'b1;
            state_d = IDLE;
          end else begin
            // Stop bit low: possibly a break; wait for the line to recover.
            fe_d    = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    srst_d = !(state_d == DATA || state_d == STOP);
    busy_d = (state_d != IDLE);
  end

  // State, synchronizer, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sync_q        <= 2'b11;
      start_cnt_q   <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      data          <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      sampler_rst   <= 1'b1;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= {sync_q[0], raw_data};
      start_cnt_q   <= start_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      data          <= data_d;
      data_valid    <= dv_d;
      framing_error <= fe_d;
      sampler_rst   <= srst_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer with a simple 16x bit-sampler model.
module tb_uart_rx_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       raw_data = 1'b1;
  logic       estimated_data = 1'b1;
  logic       sample_clk = 1'b0;
  logic       sampler_rst;
  logic [7:0] data;
  logic       data_valid;
  logic       framing_error;
  logic       busy;

  int checks = 0;
  int failures = 0;

  uart_rx_framer #(.DATA_BITS(8), .START_SAMPLES(8)) dut (
    .clk(clk), .rst(rst), .raw_data(raw_data),
    .estimated_data(estimated_data), .sample_clk(sample_clk),
    .sampler_rst(sampler_rst), .data(data), .data_valid(data_valid),
    .framing_error(framing_error), .busy(busy)
  );

  always #5 clk = ~clk;

  // Bit sampler model: after release, strobe every 16 clk (mid-bit).
  int scnt = 0;
  always @(negedge clk) begin
    if (sampler_rst) begin
      scnt = 0;
      sample_clk = 1'b0;
    end else begin
      scnt++;
      if (scnt == 16) begin
        scnt = 0;
        sample_clk = 1'b1;
        estimated_data = raw_data;
      end else begin
        sample_clk = 1'b0;
      end
    end
  end

  // Pulse monitor.
  int         dv_cnt = 0, fe_cnt = 0, rule_bad = 0, srst_dv_bad = 0, srst_low_cycles = 0;
  logic       prev_pulse = 1'b0;
  logic [7:0] dv_log[$];
  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt++;
      dv_log.push_back(data);
      if (!sampler_rst) srst_dv_bad++;
    end
    if (framing_error) fe_cnt++;
    if (data_valid && framing_error) rule_bad++;
    if ((data_valid || framing_error) && prev_pulse) rule_bad++;
    prev_pulse = data_valid || framing_error;
    if (!sampler_rst) srst_low_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 frame, 16 clk/bit; the line is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    raw_data = 1'b0;
    wait_n(16);
    for (int i = 0; i < 8; i++) begin
      raw_data = b[i];
      wait_n(16);
    end
    raw_data = stop;
    wait_n(16);
  endtask

  int n_dv, n_fe, s0;

  initial begin
    wait_n(3);
    check("rst_srst", sampler_rst, 1);
    check("rst_data", data, 0);
    check("rst_dv", data_valid, 0);
    check("rst_fe", framing_error, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    wait_n(4);

    // Nominal frame with release timing.
    n_dv = dv_cnt;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_n(9);
        check("srst_hold_9", sampler_rst, 1);
        wait_n(1);
        check("srst_fall_10", sampler_rst, 0);
      end
    join
    raw_data = 1'b1;
    wait_n(8);
    check("nom_dv_cnt", dv_cnt - n_dv, 1);
    check("nom_dv_val", dv_log[n_dv], 8'hA5);
    check("nom_data", data, 8'hA5);
    check("nom_busy", busy, 0);

    // Glitch rejection.
    n_dv = dv_cnt; n_fe = fe_cnt; s0 = srst_low_cycles;
    raw_data = 1'b0;
    wait_n(5);
    raw_data = 1'b1;
    wait_n(12);
    check("gl_srst_low", srst_low_cycles - s0, 0);
    check("gl_busy", busy, 0);
    check("gl_dv", dv_cnt - n_dv, 0);
    check("gl_fe", fe_cnt - n_fe, 0);
    send_frame(8'h3C, 1'b1);
    wait_n(8);
    check("gl_data", data, 8'h3C);
    check("gl_dv_after", dv_cnt - n_dv, 1);

    // Framing error followed by a 40-bit break.
    n_dv = dv_cnt; n_fe = fe_cnt;
    send_frame(8'h00, 1'b0);
    s0 = srst_low_cycles;
    wait_n(640);
    check("brk_fe", fe_cnt - n_fe, 1);
    check("brk_dv", dv_cnt - n_dv, 0);
    check("brk_data", data, 8'h3C);
    check("brk_busy", busy, 1);
    check("brk_srst_low", srst_low_cycles - s0, 0);
    raw_data = 1'b1;
    wait_n(8);
    check("brk_idle", busy, 0);
    send_frame(8'h81, 1'b1);
    wait_n(8);
    check("brk_next_data", data, 8'h81);
    check("brk_next_dv", dv_cnt - n_dv, 1);

    // Back-to-back frames.
    n_dv = dv_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    wait_n(8);
    check("b2b_cnt", dv_cnt - n_dv, 3);
    check("b2b_0", dv_log[n_dv], 8'h00);
    check("b2b_1", dv_log[n_dv+1], 8'hFF);
    check("b2b_2", dv_log[n_dv+2], 8'h55);

    // Reset during data bit 4 of 0xF0.
    n_dv = dv_cnt; n_fe = fe_cnt;
    raw_data = 1'b0;
    wait_n(16 + 4 * 16);
    raw_data = 1'b1;
    wait_n(8);
    rst = 1'b1;
    wait_n(1);
    check("mrst_srst", sampler_rst, 1);
    check("mrst_data", data, 0);
    check("mrst_dv", data_valid, 0);
    check("mrst_fe", framing_error, 0);
    check("mrst_busy", busy, 0);
    rst = 1'b0;
    wait_n(71);
    check("mrst_no_pulse", (dv_cnt - n_dv) + (fe_cnt - n_fe), 0);
    send_frame(8'h12, 1'b1);
    wait_n(8);
    check("mrst_next_data", data, 8'h12);
    check("mrst_next_dv", dv_cnt - n_dv, 1);

    check("pulse_rules", rule_bad, 0);
    check("srst_at_dv", srst_dv_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
- UART receive frame controller, 8N1 by default. Sits between the raw RX pin and the bit sampler, which it controls.
- Detects and qualifies the start bit on a synchronized copy of the RX line, then holds the bit sampler in reset until the start bit is qualified.
- After release, it consumes the sampler's per-bit decisions (estimated_data qualified by sample_clk) and assembles the data bits LSB first.
- Checks the stop bit and emits either a one-cycle data_valid with the byte or a one-cycle framing_error.

Parameters:
- DATA_BITS, 8: data bits per frame (LSB first); legal range 5..9.
- START_SAMPLES, 8: consecutive synchronized low samples needed to qualify a start bit (half a bit at 16x oversampling); legal range 2..15.

Ports:
- clk  input  1  16x bitrate clock, shared with the bit sampler.
- rst  input  1  synchronous, active-high reset.
- raw_data  input  1  asynchronous RX line; synchronized internally.
- estimated_data  input  1  bit decision from the bit sampler.
- sample_clk  input  1  one-cycle strobe from the bit sampler; estimated_data is valid on the same cycle.
- sampler_rst  output  1  registered reset to the bit sampler; 1 = hold sampler in reset.
- data  output  DATA_BITS  last good received word; holds between frames.
- data_valid  output  1  one-cycle pulse; data updated on this same cycle.
- framing_error  output  1  one-cycle pulse when the stop bit is sampled as 0.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: one clock; synchronous active-high rst.
  - Outputs: sampler_rst=1, data=0, data_valid=0, framing_error=0, busy=0.
  - Internal: state=IDLE; synchronizer flops=1; counters=0.
  - rst asserted mid-frame aborts the frame with no data_valid or framing_error pulse.
- Synchronizer: two flops, reset to 1. rx_s = raw_data delayed 2 clk.
- All outputs are registered.
- States:
  - IDLE: sampler_rst=1. On rx_s=0, go to START with start_cnt=1.
  - START: sampler_rst=1.
    - rx_s=0: start_cnt increments.
    - rx_s=1 before start_cnt reaches START_SAMPLES: go to IDLE and clear start_cnt (glitch rejected).
    - On the edge where start_cnt reaches START_SAMPLES: go to DATA; sampler_rst=0 from that edge. With defaults, sampler_rst falls 10 clk after the first low raw_data sample.
  - DATA: sampler_rst=0. Ignore all cycles without sample_clk.
    - On each sample_clk: shift_reg <= {estimated_data, shift_reg[DATA_BITS-1:1]}; bit_cnt++.
    - On the DATA_BITS-th sample_clk: go to STOP.
  - STOP: sampler_rst=0. On sample_clk:
    - estimated_data=1: data<=shift_reg, data_valid=1 for one cycle, sampler_rst=1, go to IDLE.
    - estimated_data=0: framing_error=1 for one cycle, data unchanged, sampler_rst=1, go to WAIT_IDLE.
  - WAIT_IDLE: sampler_rst=1. Go to IDLE on the first rx_s=1. This prevents a break condition (line held low) from retriggering a start bit.
- Counters:
  - bit_cnt is wide enough for DATA_BITS and cleared on entry to DATA.
  - start_cnt saturates at START_SAMPLES and never wraps.
- data_valid and framing_error are never high together and never high for two consecutive cycles.
- Back-to-back frames: a start edge arriving in the IDLE cycle immediately after data_valid is accepted. No dead cycles are required beyond the return to IDLE.
- sample_clk received while sampler_rst=1 (IDLE, START, WAIT_IDLE) is ignored.

Test Plan:
- Nominal frame:
  - Stimulus: DATA_BITS=8, bit_sampler instantiated, 16 clk/bit; send 0xA5 with a high stop bit.
  - Required: exactly one data_valid; data=0xA5; sampler_rst falls 10 clk after the start edge and rises with data_valid; busy low afterwards.
- Glitch rejection:
  - Stimulus: raw_data low for 5 clk, then high.
  - Required: sampler_rst stays 1; state returns to IDLE; no data_valid or framing_error.
  - Then a valid 0x3C frame: data=0x3C.
- Framing error / break:
  - Stimulus: send 0x00 with stop bit 0, line held low for 40 further bits.
  - Required: one framing_error pulse; data keeps its prior value; no new start detected until raw_data goes high; a following 0x81 frame is received correctly.
- Back-to-back:
  - Stimulus: frames 0x00, 0xFF, 0x55 with no idle gap between stop and next start.
  - Required: three data_valid pulses in order with the correct values.
- Reset mid-frame:
  - Stimulus: assert rst for 1 clk during data bit 4 of 0xF0, then send 0x12.
  - Required: all outputs return to reset values on the next edge; no pulse for the aborted frame; data=0x12 after the next frame.
